// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle MIPS-subset core (datapath + main control FSM) on a req/ack memory port.
// Build option: define MC_BNE_EN to make opcode 0x05 (bne) a legal branch; otherwise it halts.
module mc_mips_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halt
);

    // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are decoded from the state and
    // registered values only, so they stay constant while waiting. An access completes in the
    // cycle mem_ack is high while mem_req is high; mem_ack in any non-requesting state is ignored.

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rf [32];

    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_res;
    logic              funct_ok;
    logic              br_take;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              unused_shamt;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sext_imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign pc_ext   = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    assign unused_shamt = &{1'b0, ir[10:6]};

    // r0 is hard-wired to zero on the read side as well as never being written.
    assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

    always_comb begin
        alu_res  = '0;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_res = a_q + b_q;
            FN_SUB:  alu_res = a_q - b_q;
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: funct_ok = 1'b0;
        endcase
    end

`ifdef MC_BNE_EN
    assign br_take = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
    assign br_take = (a_q == b_q);
`endif

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        case (state)
            S_ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
            end
            S_ADDIWB: rf_we = 1'b1;
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = data_q;
            end
            default: rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        halt     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE: state_nx = funct_ok ? S_EXEC : S_HALT;
                    OP_LW:    state_nx = S_MEMADR;
                    OP_SW:    state_nx = S_MEMADR;
                    OP_BEQ:   state_nx = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:   state_nx = S_BRANCH;
`endif
                    OP_ADDI:  state_nx = S_ADDIEX;
                    OP_J:     state_nx = S_JUMP;
                    default:  state_nx = S_HALT;
                endcase
            end
            S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out[ADDR_W-1:0];
                if (mem_ack) state_nx = S_MEMWB;
            end
            S_MEMWB: state_nx = S_FETCH;
            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_out[ADDR_W-1:0];
                if (mem_ack) state_nx = S_FETCH;
            end
            S_EXEC:   state_nx = S_ALUWB;
            S_ALUWB:  state_nx = S_FETCH;
            S_ADDIEX: state_nx = S_ADDIWB;
            S_ADDIWB: state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_JUMP:   state_nx = S_FETCH;
            S_HALT: begin
                halt     = 1'b1;
                state_nx = S_HALT;
            end
            default: state_nx = S_HALT;
        endcase
    end

    // DECODE precomputes the branch target (PC already points past the branch).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir   <= mem_rdata[31:0];
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    a_q     <= rs_val;
                    b_q     <= rt_val;
                    alu_out <= pc_ext + sext_imm;
                end
                S_MEMADR: alu_out <= a_q + sext_imm;
                S_MEMRD: begin
                    if (mem_ack) data_q <= mem_rdata;
                end
                S_EXEC:   alu_out <= alu_res;
                S_ADDIEX: alu_out <= a_q + sext_imm;
                S_BRANCH: begin
                    if (br_take) pc_q <= alu_out[ADDR_W-1:0];
                end
                S_JUMP:   pc_q <= ir[ADDR_W-1:0];
                default:  pc_q <= pc_q;
            endcase
        end
    end

    assign mem_wdata = b_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_mc_mips_core.sv
// tb_mc_mips_core: directed and random programs on mc_mips_core, checked against an
// instruction-level reference model; the memory model inserts programmable wait states.
`timescale 1ns/1ps
module tb_mc_mips_core;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int MEM_N  = 1 << ADDR_W;
    localparam int WLOG_W = ADDR_W + DATA_W;
    localparam logic [31:0] HALT_INS = 32'hFC00_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] pc;
    logic              halt;

    logic [DATA_W-1:0] prog [MEM_N];
    logic [DATA_W-1:0] mem  [MEM_N];
    logic [WLOG_W-1:0] act_q[$];
    logic [WLOG_W-1:0] exp_q[$];
    int unsigned       wait_cfg = 0;
    int unsigned       wait_cnt;
    int unsigned       stall_viol = 0;
    logic              in_wait;
    logic [ADDR_W-1:0] last_addr;
    logic              last_we;
    int                n_vec = 0;
    int                n_err = 0;

    mc_mips_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .halt(halt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- memory model with wait states ----------------
    assign mem_ack   = mem_req && (wait_cnt == wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= prog[i];
            wait_cnt <= 0;
            in_wait  <= 1'b0;
        end else begin
            if (in_wait && mem_req && (mem_addr !== last_addr || mem_we !== last_we))
                stall_viol <= stall_viol + 1;
            if (mem_req && mem_ack && mem_we) begin
                mem[mem_addr] <= mem_wdata;
                act_q.push_back({mem_addr, mem_wdata});
            end
            wait_cnt  <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;
            in_wait   <= mem_req && !mem_ack;
            last_addr <= mem_addr;
            last_we   <= mem_we;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < MEM_N; i++) prog[i] = HALT_INS;
    endtask

    // ---------------- reference model: instruction-level interpreter ----------------
    task automatic model_run(input int w, output int cycles, output logic [ADDR_W-1:0] end_pc);
        logic [DATA_W-1:0] m [MEM_N];
        logic [DATA_W-1:0] r [32];
        logic [ADDR_W-1:0] p, np, ea;
        logic [31:0]       ins;
        logic [DATA_W-1:0] si, res;
        logic [5:0]        op, fn;
        int                rs, rt, rd;
        bit                illegal, done;
        for (int i = 0; i < MEM_N; i++) m[i] = prog[i];
        for (int i = 0; i < 32; i++) r[i] = '0;
        exp_q.delete();
        p = '0; cycles = 0; end_pc = '0; done = 1'b0;
        for (int step = 0; step < 4000 && !done; step++) begin
            ins = m[p];
            op = ins[31:26]; fn = ins[5:0];
            rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            si = {{(DATA_W-16){ins[15]}}, ins[15:0]};
            ea = ADDR_W'(r[rs] + si);
            np = p + 1'b1;
            illegal = 1'b0;
            res = '0;
            cycles += 1 + w;
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: res = r[rs] + r[rt];
                        6'h22: res = r[rs] - r[rt];
                        6'h24: res = r[rs] & r[rt];
                        6'h25: res = r[rs] | r[rt];
                        6'h2A: res = ($signed(r[rs]) < $signed(r[rt])) ? DATA_W'(1) : '0;
                        default: illegal = 1'b1;
                    endcase
                    if (!illegal) begin cycles += 3; r[rd] = res; end
                end
                6'h23: begin cycles += 4 + w; r[rt] = m[ea]; end
                6'h2B: begin
                    cycles += 3 + w;
                    m[ea] = r[rt];
                    exp_q.push_back({ea, r[rt]});
                end
                6'h04: begin cycles += 2; if (r[rs] == r[rt]) np = np + ADDR_W'(si); end
`ifdef MC_BNE_EN
                6'h05: begin cycles += 2; if (r[rs] != r[rt]) np = np + ADDR_W'(si); end
`endif
                6'h08: begin cycles += 3; r[rt] = r[rs] + si; end
                6'h02: begin cycles += 2; np = ins[ADDR_W-1:0]; end
                default: illegal = 1'b1;
            endcase
            if (illegal) begin cycles += 1; done = 1'b1; end
            r[0] = '0;
            end_pc = np;
            p = np;
        end
    endtask

    // ---------------- run a program on the DUT and score it against the model ----------------
    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halt && cycles < budget) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic check_run(input string tag, input int w, output int dc, output int base);
        int                mc;
        logic [ADDR_W-1:0] mpc;
        model_run(w, mc, mpc);
        wait_cfg = w;
        base = act_q.size();
        do_reset();
        run_to_halt(mc + 40, dc);
        chk({tag, " halt"}, 64'(halt), 64'd1);
        chk({tag, " cycles"}, 64'(dc), 64'(mc));
        chk({tag, " pc"}, 64'(pc), 64'(mpc));
        chk({tag, " nwr"}, 64'(act_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++)
            chk({tag, " wr"}, 64'(act_q[base+i]), 64'(exp_q[i]));
    endtask

    task automatic gen_random();
        int blen, kind, kmax, rs, rt, rd, off;
        int fns[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        clear_prog();
        for (int i = 32'h20; i < MEM_N; i++) prog[i] = $urandom;
        blen = $urandom_range(10, 16);
`ifdef MC_BNE_EN
        kmax = 7;
`else
        kmax = 6;
`endif
        for (int idx = 0; idx < blen; idx++) begin
            kind = $urandom_range(0, kmax);
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            off = $urandom_range(0, 2);
            if (idx + 1 + off > blen) off = blen - idx - 1;
            case (kind)
                0: prog[idx] = enc_i(8'h08, rs, rt, $urandom_range(0, 65535));
                2: prog[idx] = enc_i(8'h23, 0, rt, $urandom_range(32'h20, 32'h37));
                3: prog[idx] = enc_i(8'h2B, 0, rt, $urandom_range(32'h20, 32'h37));
                4: prog[idx] = enc_i(8'h04, rs, rt, off);
                5: prog[idx] = enc_i(8'h02, 0, 0, idx + 1 + off);
                7: prog[idx] = enc_i(8'h05, rs, rt, off);
                default: prog[idx] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
            endcase
        end
        for (int k = 1; k <= 7; k++) prog[blen + k - 1] = enc_i(8'h2B, 0, k, 32'h37 + k);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int dc, base, c;
        logic [ADDR_W-1:0] exp_pc;

        // reset state and first fetch, plan program loaded
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 1, 5);
        prog[1] = enc_i(8'h08, 0, 2, 7);
        prog[2] = enc_r(1, 2, 3, 32'h20);
        prog[3] = enc_i(8'h2B, 0, 3, 32'h10);
        prog[4] = enc_i(8'h23, 0, 4, 32'h10);
        prog[5] = enc_i(8'h2B, 0, 4, 32'h11);
        wait_cfg = 0;
        #1 rst = 1'b1;
        #1;
        chk("rst pc", 64'(pc), 64'd0);
        chk("rst halt", 64'(halt), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("cyc0 mem_req", 64'(mem_req), 64'd1);
        chk("cyc0 mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        #1 chk("first ack pc", 64'(pc), 64'd1);

        // addi/addi/add/sw/lw (+sw r4 to observe r4) with zero wait states
        check_run("plan", 0, dc, base);
        chk("plan cycles abs", 64'(dc), 64'd27);
        chk("plan sw 0x10", 64'(act_q[base]), 64'({6'h10, 32'd12}));
        chk("plan r4 via sw", 64'(act_q[base+1]), 64'({6'h11, 32'd12}));

        // beq r1,r1,-1 at PC 3: pc cycles 3 -> 4 -> 3 forever, no writes
        clear_prog();
        for (int i = 0; i < 3; i++) prog[i] = enc_i(8'h08, 0, 1, 1);
        prog[3] = enc_i(8'h04, 1, 1, 32'hFFFF);
        wait_cfg = 0;
        base = act_q.size();
        do_reset();
        for (c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (c >= 13) begin
                exp_pc = (((c - 13) % 3) == 2) ? 6'd3 : 6'd4;
                chk("beq loop pc", 64'(pc), 64'(exp_pc));
            end
        end
        chk("beq loop nwr", 64'(act_q.size() - base), 64'd0);
        chk("beq loop halt", 64'(halt), 64'd0);

        // three wait states on every access; lw alone is 11 cycles
        clear_prog();
        prog[0] = enc_i(8'h23, 0, 4, 32'h10);
        prog[1] = enc_i(8'h2B, 0, 4, 32'h11);
        prog[32'h10] = 32'hDEAD_BEEF;
        c = stall_viol;
        check_run("wait3", 3, dc, base);
        chk("wait3 cycles abs", 64'(dc), 64'd26);
        chk("wait3 sw data", 64'(act_q[base]), 64'({6'h11, 32'hDEAD_BEEF}));
        chk("wait3 stable", 64'(stall_viol - c), 64'd0);

        // illegal opcode 0x3F halts after DECODE, no writes, rst clears halt
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 1, 3);
        prog[2] = enc_i(8'h2B, 0, 1, 0);
        check_run("ill op", 0, dc, base);
        chk("ill op cycles abs", 64'(dc), 64'd6);
        repeat (5) @(posedge clk);
        #1;
        chk("ill op still halt", 64'(halt), 64'd1);
        chk("ill op mem_req", 64'(mem_req), 64'd0);
        chk("ill op pc frozen", 64'(pc), 64'd2);
        chk("ill op nwr", 64'(act_q.size() - base), 64'd0);
        rst = 1'b1;
        #1 chk("rst clears halt", 64'(halt), 64'd0);

        // unsupported funct halts
        clear_prog();
        prog[0] = enc_r(0, 0, 1, 32'h21);
        prog[1] = enc_i(8'h2B, 0, 0, 32'h20);
        check_run("ill fn", 0, dc, base);
        chk("ill fn cycles abs", 64'(dc), 64'd2);

        // sub wraps, signed slt, and bne (legal only with the option)
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 1, 1);
        prog[1] = enc_r(0, 1, 5, 32'h22);
        prog[2] = enc_r(5, 0, 6, 32'h2A);
        prog[3] = enc_i(8'h2B, 0, 5, 32'h20);
        prog[4] = enc_i(8'h2B, 0, 6, 32'h21);
        prog[5] = enc_i(8'h05, 1, 0, 2);
        prog[6] = enc_i(8'h2B, 0, 1, 32'h22);
        prog[7] = enc_i(8'h2B, 0, 1, 32'h23);
        prog[8] = enc_i(8'h2B, 0, 6, 32'h24);
        check_run("subslt", 0, dc, base);
        chk("sub all ones", 64'(act_q[base]), 64'({6'h20, 32'hFFFF_FFFF}));
        chk("slt neg", 64'(act_q[base+1]), 64'({6'h21, 32'd1}));
`ifdef MC_BNE_EN
        chk("bne pc", 64'(pc), 64'd10);
`else
        chk("bne illegal pc", 64'(pc), 64'd6);
`endif

        // reset in the middle of a waited store: abandoned, no write, restart at 0
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 1, 9);
        prog[1] = enc_i(8'h2B, 0, 1, 32'h30);
        wait_cfg = 3;
        base = act_q.size();
        do_reset();
        for (c = 0; c < 40 && !mem_we; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid we seen", 64'(mem_we), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid we drop", 64'(mem_we), 64'd0);
        chk("rstmid addr", 64'(mem_addr), 64'd0);
        chk("rstmid pc", 64'(pc), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstmid nwr", 64'(act_q.size() - base), 64'd0);

        // random programs, random wait states
        for (int t = 0; t < 25; t++) begin
            gen_random();
            check_run("rand", $urandom_range(0, 2), dc, base);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
